// File: rtl/clock_monitor_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | clock_monitor_pkg                                                  |
// | Shared state encoding and default sizing for the clock monitor.    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package clock_monitor_pkg;

    localparam int          c_cnt_w   = 24;
    localparam logic [23:0] c_timeout = 24'd5_400_000;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARM     = 2'd1,
        ST_MEASURE = 2'd2,
        ST_STALL   = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/sig_edge_detect.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sig_edge_detect                                                    |
// | Two-flop synchronizer plus history flop with rise/fall strobes.    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module sig_edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic rise,
    output logic fall,
    output logic level
);

    logic r_meta;
    logic r_sync;
    logic r_hist;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_hist <= 1'b0;
        end else begin
            r_meta <= din;
            r_sync <= r_meta;
            r_hist <= r_sync;
        end
    end

    assign rise  = r_sync & ~r_hist;
    assign fall  = ~r_sync & r_hist;
    assign level = r_sync;

endmodule
`default_nettype wire

// File: rtl/clock_monitor.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | clock_monitor                                                      |
// | Measures period and high time of a slow clock, flags stalls.       |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module clock_monitor
    import clock_monitor_pkg::*;
#(
    parameter int               CNT_W   = c_cnt_w,
    parameter logic [CNT_W-1:0] TIMEOUT = c_timeout
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sig_in,
    input  logic             enable,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             period_valid,
    output logic             stalled,
    output logic [15:0]      edge_count
);

    localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);

    logic             w_rise;
    logic             w_level;

    state_t           r_state,        w_state_nxt;
    logic [CNT_W-1:0] r_cnt,          w_cnt_nxt;
    logic [CNT_W-1:0] r_hcnt,         w_hcnt_nxt;
    logic [CNT_W-1:0] r_period,       w_period_nxt;
    logic [CNT_W-1:0] r_high_time,    w_high_nxt;
    logic             r_period_valid, w_valid_nxt;
    logic             r_stalled,      w_stalled_nxt;
    logic [15:0]      r_edge_count,   w_edge_nxt;

    logic [CNT_W-1:0] w_cnt_inc;
    logic [CNT_W-1:0] w_hcnt_inc;

    sig_edge_detect u_edge (
        .clk   (clk),
        .reset (reset),
        .din   (sig_in),
        .rise  (w_rise),
        .fall  (),
        .level (w_level)
    );

    // Counters stick at all-ones rather than wrapping into a bogus short period
    assign w_cnt_inc  = (&r_cnt)  ? r_cnt  : r_cnt  + c_cnt_one;
    assign w_hcnt_inc = (&r_hcnt) ? r_hcnt : r_hcnt + c_cnt_one;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= ST_IDLE;
            r_cnt          <= '0;
            r_hcnt         <= '0;
            r_period       <= '0;
            r_high_time    <= '0;
            r_period_valid <= 1'b0;
            r_stalled      <= 1'b0;
            r_edge_count   <= 16'd0;
        end else begin
            r_state        <= w_state_nxt;
            r_cnt          <= w_cnt_nxt;
            r_hcnt         <= w_hcnt_nxt;
            r_period       <= w_period_nxt;
            r_high_time    <= w_high_nxt;
            r_period_valid <= w_valid_nxt;
            r_stalled      <= w_stalled_nxt;
            r_edge_count   <= w_edge_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_hcnt_nxt    = r_hcnt;
        w_period_nxt  = r_period;
        w_high_nxt    = r_high_time;
        w_valid_nxt   = 1'b0;
        w_stalled_nxt = r_stalled;
        w_edge_nxt    = r_edge_count;

        if (!enable) begin
            // Disable beats a coincident rise: no pulse, no edge count
            w_state_nxt   = ST_IDLE;
            w_stalled_nxt = 1'b0;
            w_cnt_nxt     = '0;
            w_hcnt_nxt    = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_state_nxt = ST_ARM;
                    w_cnt_nxt   = '0;
                    w_hcnt_nxt  = '0;
                end
                ST_ARM: begin
                    // First edge only anchors the next period
                    if (w_rise) begin
                        w_state_nxt = ST_MEASURE;
                        w_cnt_nxt   = c_cnt_one;
                        w_hcnt_nxt  = c_cnt_one;
                        w_edge_nxt  = r_edge_count + 16'd1;
                    end else if (r_cnt == TIMEOUT) begin
                        w_state_nxt   = ST_STALL;
                        w_stalled_nxt = 1'b1;
                    end else begin
                        w_cnt_nxt = w_cnt_inc;
                    end
                end
                ST_MEASURE: begin
                    if (w_rise) begin
                        w_period_nxt = r_cnt;
                        w_high_nxt   = r_hcnt;
                        w_valid_nxt  = 1'b1;
                        w_cnt_nxt    = c_cnt_one;
                        w_hcnt_nxt   = c_cnt_one;
                        w_edge_nxt   = r_edge_count + 16'd1;
                    end else if (r_cnt == TIMEOUT) begin
                        w_state_nxt   = ST_STALL;
                        w_stalled_nxt = 1'b1;
                    end else begin
                        w_cnt_nxt = w_cnt_inc;
                        if (w_level) begin
                            w_hcnt_nxt = w_hcnt_inc;
                        end
                    end
                end
                ST_STALL: begin
                    if (w_rise) begin
                        w_state_nxt   = ST_MEASURE;
                        w_stalled_nxt = 1'b0;
                        w_cnt_nxt     = c_cnt_one;
                        w_hcnt_nxt    = c_cnt_one;
                        w_edge_nxt    = r_edge_count + 16'd1;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    assign period       = r_period;
    assign high_time    = r_high_time;
    assign period_valid = r_period_valid;
    assign stalled      = r_stalled;
    assign edge_count   = r_edge_count;

endmodule
`default_nettype wire

// File: tb/tb_clock_monitor.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_clock_monitor                                                   |
// | Directed + random bench against a waveform-level reference model.  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_clock_monitor;

    localparam int CNT_W = 24;
    localparam int TMO   = 100;
    localparam int LAT   = 3;     // sig_in change to registered output: 2 sync flops + output reg

    logic             clk = 1'b0;
    logic             reset;
    logic             sig_in;
    logic             enable;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high_time;
    logic             period_valid;
    logic             stalled;
    logic [15:0]      edge_count;

    int checks = 0;
    int errors = 0;

    clock_monitor #(.CNT_W(CNT_W), .TIMEOUT(24'd100)) dut (
        .clk          (clk),
        .reset        (reset),
        .sig_in       (sig_in),
        .enable       (enable),
        .period       (period),
        .high_time    (high_time),
        .period_valid (period_valid),
        .stalled      (stalled),
        .edge_count   (edge_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int t;
        int hi;
    } rise_ev_t;

    rise_ev_t ev_q[$];
    int  now = 0;
    bit  m_idle = 1'b1;
    bit  m_ref = 1'b0;
    bit  m_stall = 1'b0;
    int  m_rr = 0;
    int  e_period = 0;
    int  e_high = 0;
    int  e_edge = 0;
    int  d_rise = 0;
    int  d_fall = 0;
    bit  quiet = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // A rise is described by when it was driven and how long the prior high phase lasted
    task automatic set_sig(input logic v);
        rise_ev_t ev;
        if (v && !sig_in) begin
            ev.t  = now + LAT;
            ev.hi = d_fall - d_rise;
            ev_q.push_back(ev);
            d_rise = now;
        end else if (!v && sig_in) begin
            d_fall = now;
        end
        sig_in = v;
    endtask

    task automatic tick();
        logic     en_b;
        logic     rst_b;
        bit       exp_v;
        rise_ev_t ev;
        en_b  = enable;
        rst_b = reset;
        @(posedge clk);
        #1;
        now++;
        exp_v = 1'b0;
        while (ev_q.size() > 0 && ev_q[0].t < now) void'(ev_q.pop_front());
        if (rst_b) begin
            ev_q.delete();
            m_idle = 1'b1; m_ref = 1'b0; m_stall = 1'b0;
            e_period = 0; e_high = 0; e_edge = 0;
        end else if (!en_b) begin
            m_idle = 1'b1; m_ref = 1'b0; m_stall = 1'b0;
            if (ev_q.size() > 0 && ev_q[0].t == now) void'(ev_q.pop_front());
        end else if (m_idle) begin
            m_idle = 1'b0;
            if (ev_q.size() > 0 && ev_q[0].t == now) void'(ev_q.pop_front());
        end else if (ev_q.size() > 0 && ev_q[0].t == now) begin
            ev = ev_q.pop_front();
            e_edge = (e_edge + 1) % 65536;
            if (m_ref && !m_stall) begin
                exp_v    = 1'b1;
                e_period = now - m_rr;
                e_high   = ev.hi;
            end
            m_ref = 1'b1; m_stall = 1'b0; m_rr = now;
        end else if (m_ref && !m_stall && (now - m_rr) >= TMO) begin
            m_stall = 1'b1;
        end
        if (!quiet) begin
            chk("period_valid", 32'(period_valid), 32'(exp_v));
            chk("period",       32'(period),       32'(e_period));
            chk("high_time",    32'(high_time),    32'(e_high));
            chk("edge_count",   32'(edge_count),   32'(e_edge));
            chk("stalled",      32'(stalled),      32'(m_stall));
        end
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic wave(input int hi, input int lo);
        set_sig(1'b1); ticks(hi);
        set_sig(1'b0); ticks(lo);
    endtask

    initial begin
        int h;
        int l;
        reset = 1'b1; enable = 1'b0; sig_in = 1'b0;
        ticks(2);
        chk("reset_period", 32'(period), 32'd0);
        chk("reset_edges",  32'(edge_count), 32'd0);
        reset = 1'b0;
        ticks(1);
        enable = 1'b1;
        ticks(2);

        // 10 high / 10 low
        repeat (5) wave(10, 10);
        chk("sq_period", 32'(period), 32'd20);
        chk("sq_high",   32'(high_time), 32'd10);

        // 3 high / 7 low
        repeat (3) wave(3, 7);
        chk("duty_period", 32'(period), 32'd10);
        chk("duty_high",   32'(high_time), 32'd3);

        // Long low: stall, recovery edge gives no pulse, the following one does
        wave(3, 150);
        chk("stall_flag",   32'(stalled), 32'd1);
        chk("stall_period", 32'(period), 32'd10);
        wave(5, 5);
        chk("unstall_flag", 32'(stalled), 32'd0);
        wave(5, 5);
        chk("after_stall_period", 32'(period), 32'd10);

        // Period exactly TIMEOUT: rise wins, no stall
        repeat (2) wave(50, 50);
        wave(4, 4);
        chk("tmo_period", 32'(period), 32'd100);
        chk("tmo_nostall", 32'(stalled), 32'd0);

        // Random duty/period
        for (int i = 0; i < 30; i++) begin
            h = int'($urandom_range(1, 40));
            l = int'($urandom_range(1, 40));
            wave(h, l);
        end

        // Enable dropped mid-period, then re-armed
        set_sig(1'b1); ticks(4);
        enable = 1'b0; ticks(3);
        chk("dis_stalled", 32'(stalled), 32'd0);
        set_sig(1'b0); ticks(5);
        enable = 1'b1; ticks(2);
        wave(6, 6);
        wave(6, 6);
        chk("rearm_period", 32'(period), 32'd12);

        // Reset mid-measurement
        set_sig(1'b1); ticks(5);
        set_sig(1'b0); ticks(4);
        reset = 1'b1; ticks(1);
        reset = 1'b0;
        chk("rst_mid_edges",  32'(edge_count), 32'd0);
        chk("rst_mid_period", 32'(period), 32'd0);
        ticks(2);

        // Wrap the edge counter with fast edges
        quiet = 1'b1;
        repeat (65535) begin
            set_sig(1'b1); tick();
            set_sig(1'b0); tick();
        end
        ticks(LAT);
        quiet = 1'b0;
        ticks(1);
        chk("preload_edges", 32'(edge_count), 32'hFFFF);
        wave(2, 4);
        chk("wrap_edges", 32'(edge_count), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
